// File: rtl/tri_pixel_collector.sv
// Pixel-stream sink for the triangle rasterizer on an 8x8 grid.
// Captures emitted pixels into a 64-bit bitmap and tracks unique count, bounding box,
// duplicate and overrun flags. On completion the bitmap is drained one row per
// valid/ready acceptance, followed by a one-cycle done pulse.
module tri_pixel_collector (
  input  logic       clk,
  input  logic       reset,
  input  logic       busy,
  input  logic       po,
  input  logic [2:0] xo,
  input  logic [2:0] yo,
  input  logic       row_ready,
  output logic       row_valid,
  output logic [2:0] row_idx,
  output logic [7:0] row_data,
  output logic [6:0] pix_cnt,
  output logic [2:0] xmin,
  output logic [2:0] xmax,
  output logic [2:0] ymin,
  output logic [2:0] ymax,
  output logic       dup_err,
  output logic       overrun,
  output logic       done
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StDrain   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        busy_q;
  logic [63:0] bitmap_q, bitmap_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [2:0]  xmin_q, xmin_d, xmax_q, xmax_d;
  logic [2:0]  ymin_q, ymin_d, ymax_q, ymax_d;
  logic        dup_q, dup_d;
  logic        ovr_q, ovr_d;
  logic        rv_q, rv_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;

  logic        rise;
  logic        clear;
  logic        capture;
  logic        ovr_set;
  logic        go_drain;
  logic [5:0]  pix_pos;
  logic [2:0]  next_idx;

  assign rise     = busy & ~busy_q;
  // Bitmap bit index: row y occupies bits [8*y +: 8], column x is bit x within the row.
  assign pix_pos  = {yo, xo};
  assign next_idx = idx_q + 3'd1;

  // Next-state logic: FSM decode first, then clear, capture and drain-entry in that order
  // so a capture in the same cycle as a clear lands in the freshly cleared bitmap.
  always_comb begin
    state_d  = state_q;
    bitmap_d = bitmap_q;
    cnt_d    = cnt_q;
    xmin_d   = xmin_q;
    xmax_d   = xmax_q;
    ymin_d   = ymin_q;
    ymax_d   = ymax_q;
    dup_d    = dup_q;
    ovr_d    = ovr_q;
    rv_d     = rv_q;
    idx_d    = idx_q;
    data_d   = data_q;
    done_d   = 1'b0;
    clear    = 1'b0;
    capture  = 1'b0;
    ovr_set  = 1'b0;
    go_drain = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rise) begin
          clear   = 1'b1;
          state_d = StCollect;
        end
      end
      StCollect: begin
        capture = po;
        // The final pixel may arrive together with busy falling; it is captured first.
        if (!busy) begin
          go_drain = 1'b1;
          state_d  = StDrain;
        end
      end
      StDrain: begin
        if (rise) begin
          // New triangle preempts the drain; its first pixel belongs to the new bitmap.
          clear   = 1'b1;
          ovr_set = 1'b1;
          capture = po;
          rv_d    = 1'b0;
          state_d = StCollect;
        end else if (row_ready) begin
          if (idx_q == 3'd7) begin
            rv_d    = 1'b0;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            idx_d  = next_idx;
            data_d = bitmap_q[{next_idx, 3'b000} +: 8];
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (clear) begin
      bitmap_d = '0;
      cnt_d    = '0;
      xmin_d   = 3'd7;
      xmax_d   = 3'd0;
      ymin_d   = 3'd7;
      ymax_d   = 3'd0;
      dup_d    = 1'b0;
      ovr_d    = 1'b0;
    end

    if (ovr_set) begin
      ovr_d = 1'b1;
    end

    if (capture) begin
      if (bitmap_d[pix_pos]) begin
        dup_d = 1'b1;
      end else begin
        bitmap_d[pix_pos] = 1'b1;
        cnt_d             = cnt_d + 7'd1;
        if (xo < xmin_d) xmin_d = xo;
        if (xo > xmax_d) xmax_d = xo;
        if (yo < ymin_d) ymin_d = yo;
        if (yo > ymax_d) ymax_d = yo;
      end
    end

    if (go_drain) begin
      rv_d   = 1'b1;
      idx_d  = 3'd0;
      data_d = bitmap_d[7:0];
    end
  end

  // State and datapath registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      busy_q   <= 1'b0;
      bitmap_q <= '0;
      cnt_q    <= '0;
      xmin_q   <= 3'd7;
      xmax_q   <= 3'd0;
      ymin_q   <= 3'd7;
      ymax_q   <= 3'd0;
      dup_q    <= 1'b0;
      ovr_q    <= 1'b0;
      rv_q     <= 1'b0;
      idx_q    <= 3'd0;
      data_q   <= 8'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy;
      bitmap_q <= bitmap_d;
      cnt_q    <= cnt_d;
      xmin_q   <= xmin_d;
      xmax_q   <= xmax_d;
      ymin_q   <= ymin_d;
      ymax_q   <= ymax_d;
      dup_q    <= dup_d;
      ovr_q    <= ovr_d;
      rv_q     <= rv_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      done_q   <= done_d;
    end
  end

  assign row_valid = rv_q;
  assign row_idx   = idx_q;
  assign row_data  = data_q;
  assign pix_cnt   = cnt_q;
  assign xmin      = xmin_q;
  assign xmax      = xmax_q;
  assign ymin      = ymin_q;
  assign ymax      = ymax_q;
  assign dup_err   = dup_q;
  assign overrun   = ovr_q;
  assign done      = done_q;

endmodule

// File: tb/tb_tri_pixel_collector.sv
// Directed bench for tri_pixel_collector: a per-cycle vector table for the basic
// triangle, plus hand sequences for back-pressure, duplicates, last-pixel, overrun, reset.
module tb_tri_pixel_collector;

  logic       clk;
  logic       reset;
  logic       busy;
  logic       po;
  logic [2:0] xo;
  logic [2:0] yo;
  logic       row_ready;
  logic       row_valid;
  logic [2:0] row_idx;
  logic [7:0] row_data;
  logic [6:0] pix_cnt;
  logic [2:0] xmin, xmax, ymin, ymax;
  logic       dup_err, overrun, done;

  int n_checks = 0;
  int n_errors = 0;

  tri_pixel_collector dut (
    .clk       (clk),
    .reset     (reset),
    .busy      (busy),
    .po        (po),
    .xo        (xo),
    .yo        (yo),
    .row_ready (row_ready),
    .row_valid (row_valid),
    .row_idx   (row_idx),
    .row_data  (row_data),
    .pix_cnt   (pix_cnt),
    .xmin      (xmin),
    .xmax      (xmax),
    .ymin      (ymin),
    .ymax      (ymax),
    .dup_err   (dup_err),
    .overrun   (overrun),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       po;
    logic [2:0] x;
    logic [2:0] y;
    logic       rdy;
    logic [33:0] exp;
  } vec_t;

  vec_t       vecs[17];
  logic [7:0] exp_rows[8];
  logic [7:0] got_rows[8];
  int         acc;
  int         dones;

  function automatic logic [33:0] pack_out(
      input logic rv, input logic [2:0] idx, input logic [7:0] data, input logic [6:0] cnt,
      input logic [2:0] xmn, input logic [2:0] xmx, input logic [2:0] ymn,
      input logic [2:0] ymx, input logic dup, input logic ovr, input logic dn);
    return {rv, idx, data, cnt, xmn, xmx, ymn, ymx, dup, ovr, dn};
  endfunction

  function automatic vec_t mkv(input logic b, input logic p, input logic [2:0] x,
                               input logic [2:0] y, input logic [33:0] e);
    vec_t v;
    v.busy = b;
    v.po   = p;
    v.x    = x;
    v.y    = y;
    v.rdy  = 1'b1;
    v.exp  = e;
    return v;
  endfunction

  function automatic logic [33:0] dut_out();
    return pack_out(row_valid, row_idx, row_data, pix_cnt, xmin, xmax, ymin, ymax,
                    dup_err, overrun, done);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic pix(input logic b, input logic p, input logic [2:0] x, input logic [2:0] y);
    busy = b;
    po   = p;
    xo   = x;
    yo   = y;
    @(posedge clk);
    #1;
  endtask

  // Pixels of triangle (0,0),(2,1),(0,2) in scan order; busy drops with the last one.
  task automatic collect_tri1();
    pix(1'b1, 1'b0, 3'd0, 3'd0);
    pix(1'b1, 1'b1, 3'd0, 3'd0);
    pix(1'b1, 1'b1, 3'd0, 3'd1);
    pix(1'b1, 1'b1, 3'd1, 3'd1);
    pix(1'b1, 1'b1, 3'd2, 3'd1);
    pix(1'b0, 1'b1, 3'd0, 3'd2);
  endtask

  // Drain with row_ready high, recording every accepted row; bounded cycle budget.
  task automatic drain_all();
    for (int r = 0; r < 8; r++) got_rows[r] = 8'hxx;
    acc   = 0;
    dones = 0;
    row_ready = 1'b1;
    busy = 1'b0;
    po   = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (row_valid) begin
        got_rows[row_idx] = row_data;
        acc++;
      end
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    chk("drain_acc", acc, 8);
    chk("drain_done", dones, 1);
  endtask

  task automatic set_rows(input logic [63:0] bm);
    for (int r = 0; r < 8; r++) exp_rows[r] = bm[r*8 +: 8];
  endtask

  task automatic cmp_rows(input string tag);
    for (int r = 0; r < 8; r++) chk($sformatf("%s_row%0d", tag, r), got_rows[r], exp_rows[r]);
  endtask

  logic [33:0] rst_out;
  logic [3:0]  bp_pat;
  logic        p_rv;
  logic [2:0]  p_idx;
  logic [7:0]  p_data;

  initial begin
    rst_out = pack_out(1'b0, 3'd0, 8'h00, 7'd0, 3'd7, 3'd0, 3'd7, 3'd0, 1'b0, 1'b0, 1'b0);
    bp_pat  = 4'b1001;  // bit k%4 gives row_ready: 1,0,0,1

    // Triangle 1 cycle by cycle; expected outputs after each edge.
    vecs[0]  = mkv(1, 0, 0, 0, pack_out(0, 0, 8'h00, 0, 7, 0, 7, 0, 0, 0, 0));
    vecs[1]  = mkv(1, 1, 0, 0, pack_out(0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs[2]  = mkv(1, 1, 0, 1, pack_out(0, 0, 8'h00, 2, 0, 0, 0, 1, 0, 0, 0));
    vecs[3]  = mkv(1, 0, 0, 0, pack_out(0, 0, 8'h00, 2, 0, 0, 0, 1, 0, 0, 0));
    vecs[4]  = mkv(1, 1, 1, 1, pack_out(0, 0, 8'h00, 3, 0, 1, 0, 1, 0, 0, 0));
    vecs[5]  = mkv(1, 1, 2, 1, pack_out(0, 0, 8'h00, 4, 0, 2, 0, 1, 0, 0, 0));
    vecs[6]  = mkv(0, 1, 0, 2, pack_out(1, 0, 8'h01, 5, 0, 2, 0, 2, 0, 0, 0));
    vecs[7]  = mkv(0, 0, 0, 0, pack_out(1, 1, 8'h07, 5, 0, 2, 0, 2, 0, 0, 0));
    vecs[8]  = mkv(0, 0, 0, 0, pack_out(1, 2, 8'h01, 5, 0, 2, 0, 2, 0, 0, 0));
    vecs[9]  = mkv(0, 0, 0, 0, pack_out(1, 3, 8'h00, 5, 0, 2, 0, 2, 0, 0, 0));
    vecs[10] = mkv(0, 0, 0, 0, pack_out(1, 4, 8'h00, 5, 0, 2, 0, 2, 0, 0, 0));
    vecs[11] = mkv(0, 0, 0, 0, pack_out(1, 5, 8'h00, 5, 0, 2, 0, 2, 0, 0, 0));
    vecs[12] = mkv(0, 0, 0, 0, pack_out(1, 6, 8'h00, 5, 0, 2, 0, 2, 0, 0, 0));
    vecs[13] = mkv(0, 0, 0, 0, pack_out(1, 7, 8'h00, 5, 0, 2, 0, 2, 0, 0, 0));
    vecs[14] = mkv(0, 0, 0, 0, pack_out(0, 7, 8'h00, 5, 0, 2, 0, 2, 0, 0, 1));
    vecs[15] = mkv(0, 0, 0, 0, pack_out(0, 7, 8'h00, 5, 0, 2, 0, 2, 0, 0, 0));
    // po in IDLE is ignored.
    vecs[16] = mkv(0, 1, 5, 5, pack_out(0, 7, 8'h00, 5, 0, 2, 0, 2, 0, 0, 0));

    reset = 1'b1;
    busy = 1'b0;
    po = 1'b0;
    xo = 3'd0;
    yo = 3'd0;
    row_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", dut_out(), rst_out);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset_idle", dut_out(), rst_out);

    for (int i = 0; i < 17; i++) begin
      busy = vecs[i].busy;
      po = vecs[i].po;
      xo = vecs[i].x;
      yo = vecs[i].y;
      row_ready = vecs[i].rdy;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), dut_out(), vecs[i].exp);
    end

    // Back-pressure: rows hold while row_ready=0, 8 acceptances, one done.
    set_rows(64'h0000_0000_0001_0701);
    row_ready = 1'b1;
    collect_tri1();
    for (int r = 0; r < 8; r++) got_rows[r] = 8'hxx;
    acc = 0;
    dones = 0;
    busy = 1'b0;
    po = 1'b0;
    for (int k = 0; k < 40; k++) begin
      row_ready = bp_pat[k % 4];
      p_rv = row_valid;
      p_idx = row_idx;
      p_data = row_data;
      if (row_valid && row_ready) begin
        got_rows[row_idx] = row_data;
        acc++;
      end
      @(posedge clk);
      #1;
      if (done) dones++;
      if (p_rv && !row_ready) chk("bp_hold", {row_valid, row_idx, row_data}, {1'b1, p_idx, p_data});
    end
    chk("bp_acc", acc, 8);
    chk("bp_done", dones, 1);
    cmp_rows("bp");

    // Duplicate pixel.
    row_ready = 1'b1;
    pix(1'b1, 1'b0, 3'd0, 3'd0);
    pix(1'b1, 1'b1, 3'd3, 3'd3);
    pix(1'b1, 1'b1, 3'd3, 3'd3);
    chk("dup_flag_early", dup_err, 1'b1);
    pix(1'b1, 1'b1, 3'd4, 3'd3);
    pix(1'b0, 1'b0, 3'd0, 3'd0);
    chk("dup_cnt", pix_cnt, 7'd2);
    chk("dup_flag", dup_err, 1'b1);
    chk("dup_box", {xmin, xmax, ymin, ymax}, {3'd3, 3'd4, 3'd3, 3'd3});
    set_rows(64'h0000_0000_1800_0000);
    drain_all();
    cmp_rows("dup");

    // Single pixel arriving with busy falling.
    pix(1'b1, 1'b0, 3'd0, 3'd0);
    pix(1'b0, 1'b1, 3'd7, 3'd7);
    chk("last_out", dut_out(), pack_out(1, 0, 8'h00, 1, 7, 7, 7, 7, 0, 0, 0));
    set_rows(64'h8000_0000_0000_0000);
    drain_all();
    cmp_rows("last");

    // Overrun: new triangle starts while row 2 is presented.
    row_ready = 1'b1;
    collect_tri1();
    pix(1'b0, 1'b0, 3'd0, 3'd0);
    pix(1'b0, 1'b0, 3'd0, 3'd0);
    chk("ovr_at_row2", {row_valid, row_idx}, {1'b1, 3'd2});
    pix(1'b1, 1'b1, 3'd5, 3'd5);
    chk("ovr_rv", row_valid, 1'b0);
    chk("ovr_nodone", done, 1'b0);
    chk("ovr_flag", overrun, 1'b1);
    chk("ovr_stats", {pix_cnt, xmin, xmax, ymin, ymax, dup_err},
        {7'd1, 3'd5, 3'd5, 3'd5, 3'd5, 1'b0});
    pix(1'b0, 1'b1, 3'd6, 3'd5);
    chk("ovr_new_tri", {row_valid, row_idx, row_data, pix_cnt, xmin, xmax},
        {1'b1, 3'd0, 8'h00, 7'd2, 3'd5, 3'd6});
    set_rows(64'h0000_6000_0000_0000);
    drain_all();
    cmp_rows("ovr");
    chk("ovr_sticky", overrun, 1'b1);

    // Asynchronous reset while row 4 is presented.
    row_ready = 1'b1;
    collect_tri1();
    repeat (4) pix(1'b0, 1'b0, 3'd0, 3'd0);
    chk("rst_at_row4", {row_valid, row_idx}, {1'b1, 3'd4});
    #3;
    reset = 1'b1;
    #1;
    chk("rst_async", dut_out(), rst_out);
    @(posedge clk);
    #1;
    reset = 1'b0;
    collect_tri1();
    chk("rst_recover", dut_out(), pack_out(1, 0, 8'h01, 5, 0, 2, 0, 2, 0, 0, 0));
    set_rows(64'h0000_0000_0001_0701);
    drain_all();
    cmp_rows("rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
